// File: rtl/ghash_h_powers_gen_pkg.sv
// ---------------------------------------------------------------------------
// ghash_h_powers_gen_pkg
//   Shared GHASH definitions: GF block width, reduction polynomial (GCM bit
//   order), the H-power generator FSM encoding and small elaboration helpers.
// ---------------------------------------------------------------------------
package ghash_h_powers_gen_pkg;

  // GF(2^128) block width.
  localparam int GHASH_NB_BLOCK = 128;

  // x^128 + x^7 + x^2 + x + 1 without the x^128 term, in GCM bit order
  // (bit 127 = coefficient of x^0): 0xE1 followed by 120 zero bits.
  localparam logic [GHASH_NB_BLOCK-1:0] GF_R_POLY = {8'hE1, 120'd0};

  // H-power generator states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Converts between GCM bit order and plain polynomial order
  // (bit i = coefficient of x^i); the mapping is its own inverse.
  function automatic logic [GHASH_NB_BLOCK-1:0] bit_reverse(
    input logic [GHASH_NB_BLOCK-1:0] value
  );
    logic [GHASH_NB_BLOCK-1:0] result;
    result = '0;
    for (int i = 0; i < GHASH_NB_BLOCK; i++) begin
      result[i] = value[GHASH_NB_BLOCK-1-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/ghash_h_powers_gen_mult.sv
// ---------------------------------------------------------------------------
// gf128_mult_comb
//   Purely combinational GF(2^128) multiply in GCM bit order: full 255-bit
//   carry-less product followed by reduction modulo x^128 + x^7 + x^2 + x + 1.
// Ports:
//   o_data    [127:0] out  product a (x) b, GCM bit order
//   i_data_a  [127:0] in   operand a, GCM bit order
//   i_data_b  [127:0] in   operand b, GCM bit order
// ---------------------------------------------------------------------------
module gf128_mult_comb
  import ghash_h_powers_gen_pkg::*;
(
  output logic [GHASH_NB_BLOCK-1:0] o_data,
  input  logic [GHASH_NB_BLOCK-1:0] i_data_a,
  input  logic [GHASH_NB_BLOCK-1:0] i_data_b
);

  localparam int NB      = GHASH_NB_BLOCK;
  localparam int NB_PROD = 2 * NB - 1;

  logic [NB-1:0]      a_poly_s;
  logic [NB-1:0]      b_poly_s;
  logic [NB-1:0]      red_poly_s;
  logic [NB_PROD-1:0] prod_s;

  // Carry-less product in polynomial order, then fold the high half down.
  always_comb begin
    a_poly_s   = bit_reverse(i_data_a);
    b_poly_s   = bit_reverse(i_data_b);
    red_poly_s = bit_reverse(GF_R_POLY);
    prod_s     = '0;
    for (int i = 0; i < NB; i++) begin
      if (a_poly_s[i]) begin
        prod_s = prod_s ^ ({{(NB - 1){1'b0}}, b_poly_s} << i);
      end else begin
        prod_s = prod_s;
      end
    end
    // x^d = x^(d-128) * (x^7 + x^2 + x + 1); walking downward lets the bits
    // that land at or above x^128 be folded again on later iterations.
    for (int d = NB_PROD - 1; d >= NB; d--) begin
      if (prod_s[d]) begin
        prod_s[d]          = 1'b0;
        prod_s[d - NB +: NB] = prod_s[d - NB +: NB] ^ red_poly_s;
      end else begin
        prod_s = prod_s;
      end
    end
  end

  assign o_data = bit_reverse(prod_s[NB-1:0]);

endmodule

// File: rtl/ghash_h_powers_gen.sv
// ---------------------------------------------------------------------------
// ghash_h_powers_gen
//   Builds the key-power bus H^1..H^N_BLOCKS for a multi-block GHASH core by
//   repeatedly multiplying the latched subkey into the previous power, one
//   power per clock through a single shared multiplier.
// Ports:
//   i_clock         in   clock
//   i_reset         in   synchronous active-high reset
//   i_h_key         in   hash subkey H (GCM bit order), sampled with valid
//   i_h_key_valid   in   start pulse; also restarts a running computation
//   o_h_key_powers  out  slot k = H^(k+1); slot N_BLOCKS-1 = H^N_BLOCKS
//   o_ready         out  power set complete and consistent
//   o_busy          out  computation in progress
// ---------------------------------------------------------------------------
module ghash_h_powers_gen
  import ghash_h_powers_gen_pkg::*;
#(
  parameter int NB_BLOCK = GHASH_NB_BLOCK,
  parameter int N_BLOCKS = 2,
  parameter int NB_DATA  = N_BLOCKS * NB_BLOCK
)(
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BLOCK-1:0] i_h_key,
  input  logic               i_h_key_valid,
  output logic [NB_DATA-1:0]  o_h_key_powers,
  output logic               o_ready,
  output logic               o_busy
);

  // An unsupported configuration never starts, so o_ready never rises.
  localparam logic BAD_CONF = (NB_BLOCK != GHASH_NB_BLOCK) ||
                              (N_BLOCKS < 1) || (N_BLOCKS > 16);
  localparam int   CNT_W    = clog2(N_BLOCKS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BLOCKS - 1);

  state_e                            state_r;
  state_e                            state_nxt_s;
  logic [CNT_W-1:0]                  cnt_r;
  logic [CNT_W-1:0]                  cnt_nxt_s;
  logic                              ready_r;
  logic                              ready_nxt_s;
  logic                              busy_r;
  logic                              busy_nxt_s;
  logic [NB_BLOCK-1:0]               h_key_r;
  logic [N_BLOCKS-1:0][NB_BLOCK-1:0] powers_r;
  logic                              start_s;
  logic                              load_s;
  logic                              step_s;
  logic [NB_BLOCK-1:0]               prev_s;
  logic [NB_BLOCK-1:0]               mult_s;

  assign start_s = i_h_key_valid & ~BAD_CONF;

  // Next state, counter and status flags; a start pulse wins in every state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ready_nxt_s = ready_r;
    busy_nxt_s  = busy_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    if (start_s) begin
      load_s = 1'b1;
      if (N_BLOCKS == 1) begin
        state_nxt_s = ST_DONE;
        cnt_nxt_s   = '0;
        ready_nxt_s = 1'b1;
        busy_nxt_s  = 1'b0;
      end else begin
        state_nxt_s = ST_COMPUTE;
        cnt_nxt_s   = CNT_W'(1);
        ready_nxt_s = 1'b0;
        busy_nxt_s  = 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_COMPUTE: begin
          step_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_DONE;
            ready_nxt_s = 1'b1;
            busy_nxt_s  = 1'b0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
          ready_nxt_s = 1'b0;
          busy_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // State, counter, status flags and latched subkey.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      h_key_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= ready_nxt_s;
      busy_r  <= busy_nxt_s;
      if (load_s) begin
        h_key_r <= i_h_key;
      end else begin
        h_key_r <= h_key_r;
      end
    end
  end

  // Previous power H^cnt feeding the multiplier (slot cnt-1).
  always_comb begin
    prev_s = '0;
    for (int k = 0; k < N_BLOCKS; k++) begin
      if (CNT_W'(k + 1) == cnt_r) begin
        prev_s = powers_r[k];
      end else begin
        prev_s = prev_s;
      end
    end
  end

  gf128_mult_comb u_mult (
    .o_data   (mult_s),
    .i_data_a (prev_s),
    .i_data_b (h_key_r)
  );

  // Power slots: slot 0 takes H on start, slot cnt takes the new product.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      powers_r <= '0;
    end else begin
      for (int k = 0; k < N_BLOCKS; k++) begin
        if (load_s && (k == 0)) begin
          powers_r[k] <= i_h_key;
        end else if (step_s && (CNT_W'(k) == cnt_r)) begin
          powers_r[k] <= mult_s;
        end else begin
          powers_r[k] <= powers_r[k];
        end
      end
    end
  end

  assign o_h_key_powers = powers_r;
  assign o_ready        = ready_r;
  assign o_busy         = busy_r;

endmodule
